// File: rtl/outdatalatch_seq.sv
// Data output register and external bus write-cycle sequencer (SETUP/DRIVE/HOLD) behind a 2-entry byte buffer.
// Optional macro OUTLATCH_WAIT_EN adds the bus_wait input ("wait" is a reserved word) that stretches DRIVE.
module outdatalatch_seq #(
  parameter int WIDTH    = 8,
  parameter int DRIVECYC = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef OUTLATCH_WAIT_EN
  input  logic             bus_wait,
`endif
  input  logic [WIDTH-1:0] databs,
  input  logic             ld,
  output logic             ready,
  output logic             ovf,
  output logic [WIDTH-1:0] dataout,
  output logic             dataoe,
  output logic             rw,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;
  localparam logic [3:0] DRIVE_LOAD = 4'(DRIVECYC);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            count_q, count_d;
  logic                  wptr_q, wptr_d;
  logic                  rptr_q, rptr_d;
  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic [WIDTH-1:0]      dor_q, dor_d;
  logic                  rw_q, rw_d;
  logic                  dataoe_q, dataoe_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  wait_s;

  assign ready_s = (count_q != 2'd2);

`ifdef OUTLATCH_WAIT_EN
  assign wait_s = bus_wait;
`else
  assign wait_s = 1'b0;
`endif

  // Sequencer: pops a byte into the DOR whenever a new write cycle starts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_s   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != 2'd0) begin
          pop_s   = 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_DRIVE;
        cnt_d   = DRIVE_LOAD;
      end
      S_DRIVE: begin
        if (wait_s) begin
          cnt_d = cnt_q;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        done_d = 1'b1;
        if (count_q != 2'd0) begin
          pop_s   = 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Buffer pointers/occupancy and DOR load; a full buffer drops the byte and flags overflow.
  always_comb begin
    push_s  = ld && ready_s;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    dor_d   = dor_q;
    count_d = count_q;
    if (push_s) begin
      mem_d[wptr_q] = databs;
      wptr_d        = ~wptr_q;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      dor_d  = mem_q[rptr_q];
      rptr_d = ~rptr_q;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (ld & ~ready_s);
  end

  // Bus strobes decoded from the next state so they line up with the state register.
  always_comb begin
    rw_d     = !((state_d == S_SETUP) || (state_d == S_DRIVE));
    dataoe_d = (state_d == S_DRIVE) || (state_d == S_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      count_q  <= 2'd0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      mem_q    <= '0;
      dor_q    <= '0;
      rw_q     <= 1'b1;
      dataoe_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      mem_q    <= mem_d;
      dor_q    <= dor_d;
      rw_q     <= rw_d;
      dataoe_q <= dataoe_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready   = ready_s;
  assign ovf     = ovf_q;
  assign dataout = dor_q;
  assign dataoe  = dataoe_q;
  assign rw      = rw_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;

endmodule
